// File: rtl/sb_pkg.sv
// Shared constants and helpers for the simple-bus N-master arbiter.
package sb_pkg;

    // Arbitration modes
    localparam int ARB_RR    = 0;   // round-robin, pointer advances past each accepted master
    localparam int ARB_FIXED = 1;   // fixed priority, highest master index wins

    // Default bus widths
    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    // Index width that never collapses to zero bits, so 1- and 2-entry
    // structures still get a usable pointer/index field.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sb_arb_idq.sv
// Arbiter, grant lock, round-robin pointer and in-order master-ID FIFO for
// one request/response path. Request and response forwarding is purely
// combinational; the only state is the lock, the pointer and the FIFO.
module sb_arb_idq
    import sb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int OSTD     = 2,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          clk,
    input  logic          rst,
    // master-side request handshake
    input  logic [NM-1:0] req_valid,
    output logic [NM-1:0] req_ready,
    output logic [NM-1:0] gnt,
    // slave-side request handshake
    output logic          s_valid,
    input  logic          s_ready,
    // slave-side response handshake
    input  logic          rsp_valid_s,
    output logic          rsp_ready_s,
    // master-side response handshake
    output logic [NM-1:0] rsp_valid_m,
    input  logic [NM-1:0] rsp_ready_m
);

    localparam int IW = clog2_safe(NM);     // master index width
    localparam int XW = IW + 1;             // scan width, holds pointer + offset before wrap
    localparam int PW = clog2_safe(OSTD);   // FIFO pointer width
    localparam int CW = $clog2(OSTD) + 1;   // FIFO occupancy width

    logic [IW-1:0] rr_ptr_reg, rr_ptr_next;
    logic          locked_reg, locked_next;
    logic [IW-1:0] lock_idx_reg, lock_idx_next;

    logic [IW-1:0] id_mem_reg [OSTD];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;

    logic [IW-1:0] arb_idx;
    logic          arb_any;
    logic [XW-1:0] scan_idx;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic [IW-1:0] head;
    logic          empty, full, push, pop, can_push;

    // Free arbitration: round-robin scan from the pointer, or highest index wins
    always_comb begin
        arb_idx  = '0;
        arb_any  = 1'b0;
        scan_idx = '0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < NM; i++) begin
                if (req_valid[i]) begin
                    arb_idx = IW'(i);
                    arb_any = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NM; k++) begin
                scan_idx = {1'b0, rr_ptr_reg} + XW'(k);
                if (scan_idx >= XW'(NM)) begin
                    scan_idx = scan_idx - XW'(NM);
                end
                if (!arb_any && req_valid[scan_idx[IW-1:0]]) begin
                    arb_idx = scan_idx[IW-1:0];
                    arb_any = 1'b1;
                end
            end
        end
    end

    // A locked grant overrides free arbitration until its handshake completes
    assign gnt_idx = locked_reg ? lock_idx_reg : arb_idx;
    assign gnt_any = locked_reg | arb_any;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CW'(OSTD));
    assign head     = id_mem_reg[rd_ptr_reg];

    // Responses only flow when an ID is queued, so a stray slave response stalls
    assign rsp_ready_s = !rst && !empty && rsp_ready_m[head];
    assign pop         = rsp_valid_s && rsp_ready_s;

    // A full FIFO can still take a new ID when the head retires this cycle
    assign can_push = !full || pop;
    assign s_valid  = !rst && can_push && |(req_valid & gnt);
    assign push     = s_valid && s_ready;

    for (genvar gi = 0; gi < NM; gi++) begin : g_route
        assign gnt[gi]         = gnt_any && (gnt_idx == IW'(gi));
        assign req_ready[gi]   = gnt[gi] && !rst && can_push && s_ready;
        assign rsp_valid_m[gi] = !rst && rsp_valid_s && !empty && (head == IW'(gi));
    end

    // Next lock and pointer: lock on a stalled offer, release on accept or dropped valid
    always_comb begin
        locked_next   = locked_reg;
        lock_idx_next = lock_idx_reg;
        rr_ptr_next   = rr_ptr_reg;
        if (push) begin
            locked_next = 1'b0;
            if (ARB_MODE == ARB_RR) begin
                rr_ptr_next = (gnt_idx == IW'(NM - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (s_valid) begin
            locked_next   = 1'b1;
            lock_idx_next = gnt_idx;
        end else if (locked_reg && !req_valid[lock_idx_reg]) begin
            locked_next = 1'b0;
        end
    end

    // Lock and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_reg   <= 1'b0;
            lock_idx_reg <= '0;
            rr_ptr_reg   <= '0;
        end else begin
            locked_reg   <= locked_next;
            lock_idx_reg <= lock_idx_next;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    // ID FIFO: granted index pushed on accept, head popped on response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < OSTD; i++) begin
                id_mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                id_mem_reg[wr_ptr_reg] <= gnt_idx;
                wr_ptr_reg <= (wr_ptr_reg == PW'(OSTD - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(OSTD - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/sb_nm1s_rr.sv
// N-master to 1-slave simple-bus arbiter. Read and write paths are arbitrated
// independently; each path can have up to OSTD accepted requests awaiting
// responses, which are routed back in order to the issuing master.
module sb_nm1s_rr
    import sb_pkg::*;
#(
    parameter int NM       = 2,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int OSTD     = 2,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                 clk,
    input  logic                 rst,
    // master side, read
    input  logic [NM-1:0]        sb_arvalid_m,
    output logic [NM-1:0]        sb_arready_m,
    input  logic [NM*AW-1:0]     sb_araddr_m,
    output logic [NM-1:0]        sb_rvalid_m,
    input  logic [NM-1:0]        sb_rready_m,
    output logic [DW-1:0]        sb_rdata_m,
    // master side, write
    input  logic [NM-1:0]        sb_wvalid_m,
    output logic [NM-1:0]        sb_wready_m,
    input  logic [NM*AW-1:0]     sb_waddr_m,
    input  logic [NM*DW-1:0]     sb_wdata_m,
    input  logic [NM*DW/8-1:0]   sb_wstrb_m,
    output logic [NM-1:0]        sb_bvalid_m,
    input  logic [NM-1:0]        sb_bready_m,
    output logic                 sb_bresp_m,
    // slave side, read
    output logic                 sb_arvalid_s0,
    input  logic                 sb_arready_s0,
    output logic [AW-1:0]        sb_araddr_s0,
    input  logic                 sb_rvalid_s0,
    output logic                 sb_rready_s0,
    input  logic [DW-1:0]        sb_rdata_s0,
    // slave side, write
    output logic                 sb_wvalid_s0,
    input  logic                 sb_wready_s0,
    output logic [AW-1:0]        sb_waddr_s0,
    output logic [DW-1:0]        sb_wdata_s0,
    output logic [DW/8-1:0]      sb_wstrb_s0,
    input  logic                 sb_bvalid_s0,
    output logic                 sb_bready_s0,
    input  logic                 sb_bresp_s0
);

    localparam int SW = DW / 8;

    logic [NM-1:0] ar_gnt, w_gnt;

    // Per-master payload slices, zeroed unless that master holds the grant
    logic [AW-1:0] ar_addr_slice [NM];
    logic [AW-1:0] w_addr_slice  [NM];
    logic [DW-1:0] w_data_slice  [NM];
    logic [SW-1:0] w_strb_slice  [NM];

    logic [AW-1:0] ar_addr_sel, w_addr_sel;
    logic [DW-1:0] w_data_sel;
    logic [SW-1:0] w_strb_sel;

    sb_arb_idq #(
        .NM       (NM),
        .OSTD     (OSTD),
        .ARB_MODE (ARB_MODE)
    ) u_rd_path (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (sb_arvalid_m),
        .req_ready   (sb_arready_m),
        .gnt         (ar_gnt),
        .s_valid     (sb_arvalid_s0),
        .s_ready     (sb_arready_s0),
        .rsp_valid_s (sb_rvalid_s0),
        .rsp_ready_s (sb_rready_s0),
        .rsp_valid_m (sb_rvalid_m),
        .rsp_ready_m (sb_rready_m)
    );

    sb_arb_idq #(
        .NM       (NM),
        .OSTD     (OSTD),
        .ARB_MODE (ARB_MODE)
    ) u_wr_path (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (sb_wvalid_m),
        .req_ready   (sb_wready_m),
        .gnt         (w_gnt),
        .s_valid     (sb_wvalid_s0),
        .s_ready     (sb_wready_s0),
        .rsp_valid_s (sb_bvalid_s0),
        .rsp_ready_s (sb_bready_s0),
        .rsp_valid_m (sb_bvalid_m),
        .rsp_ready_m (sb_bready_m)
    );

    for (genvar gi = 0; gi < NM; gi++) begin : g_slice
        assign ar_addr_slice[gi] = sb_araddr_m[gi*AW +: AW] & {AW{ar_gnt[gi]}};
        assign w_addr_slice[gi]  = sb_waddr_m[gi*AW +: AW]  & {AW{w_gnt[gi]}};
        assign w_data_slice[gi]  = sb_wdata_m[gi*DW +: DW]  & {DW{w_gnt[gi]}};
        assign w_strb_slice[gi]  = sb_wstrb_m[gi*SW +: SW]  & {SW{w_gnt[gi]}};
    end

    // OR-combine the masked slices; grants are one-hot so this is a plain mux
    always_comb begin
        ar_addr_sel = '0;
        w_addr_sel  = '0;
        w_data_sel  = '0;
        w_strb_sel  = '0;
        for (int i = 0; i < NM; i++) begin
            ar_addr_sel = ar_addr_sel | ar_addr_slice[i];
            w_addr_sel  = w_addr_sel  | w_addr_slice[i];
            w_data_sel  = w_data_sel  | w_data_slice[i];
            w_strb_sel  = w_strb_sel  | w_strb_slice[i];
        end
    end

    // Payload is held at zero whenever nothing is offered to the slave
    assign sb_araddr_s0 = sb_arvalid_s0 ? ar_addr_sel : '0;
    assign sb_waddr_s0  = sb_wvalid_s0  ? w_addr_sel  : '0;
    assign sb_wdata_s0  = sb_wvalid_s0  ? w_data_sel  : '0;
    assign sb_wstrb_s0  = sb_wvalid_s0  ? w_strb_sel  : '0;

    // Response payloads are broadcast; the per-master valid selects the owner
    assign sb_rdata_m = sb_rdata_s0;
    assign sb_bresp_m = sb_bresp_s0;

endmodule

// File: doc/sb_nm1s_rr.md
Name: sb_nm1s_rr

Overview:
Parametrised N-master to 1-slave arbiter for the simple bus (sb_*). It replaces the fixed two-master, one-outstanding crossbar.
- Read and write paths are arbitrated independently, with selectable round-robin or fixed priority.
- Up to OSTD address/write handshakes may be in flight per path, tracked by a master-ID FIFO that routes responses in order.
- Sits between the CPU/DMA masters and a single memory or peripheral slave port.

Parameters:
NM, 2, number of masters (2..8)
AW, 32, address width
DW, 32, data width (write strobe width is DW/8)
OSTD, 2, outstanding transactions per path (power of 2, 1..8)
ARB_MODE, 0, 0 = round-robin; 1 = fixed priority, highest master index wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sb_arvalid_m  in  NM  per-master read address valid
sb_arready_m  out  NM  per-master read address ready
sb_araddr_m  in  NM*AW  per-master read address, master i at [i*AW +: AW]
sb_rvalid_m  out  NM  per-master read data valid
sb_rready_m  in  NM  per-master read data ready
sb_rdata_m  out  DW  read data, broadcast to all masters
sb_wvalid_m  in  NM  per-master write valid
sb_wready_m  out  NM  per-master write ready
sb_waddr_m  in  NM*AW  per-master write address
sb_wdata_m  in  NM*DW  per-master write data
sb_wstrb_m  in  NM*DW/8  per-master write strobes
sb_bvalid_m  out  NM  per-master write response valid
sb_bready_m  in  NM  per-master write response ready
sb_bresp_m  out  1  write response, broadcast to all masters
sb_arvalid_s0 / sb_arready_s0 / sb_araddr_s0  out/in/out  1/1/AW  slave read address channel
sb_rvalid_s0 / sb_rready_s0 / sb_rdata_s0  in/out/in  1/1/DW  slave read data channel
sb_wvalid_s0 / sb_wready_s0  out/in  1/1  slave write handshake
sb_waddr_s0 / sb_wdata_s0 / sb_wstrb_s0  out  AW/DW/DW/8  slave write payload
sb_bvalid_s0 / sb_bready_s0 / sb_bresp_s0  in/out/in  1/1/1  slave write response channel

Behaviour:
- Read and write paths are identical structures. The description below uses read names; write is the same, with ar→w and r→b.
- Zero added latency: all request and response forwarding is combinational. The only state is the grant lock, the RR pointer and the ID FIFO.
- Reset state:
  - FIFO empty, lock clear, RR pointer 0.
  - All *_valid outputs and all *_ready outputs are 0.
  - Payload outputs are 0 (master 0 selected, masked while idle).
- Arbitration (combinational):
  - Mode 0: first requesting master at or after the RR pointer, scanning upward with wrap.
  - Mode 1: highest-index requester wins.
  - Result is a one-hot grant gnt.
- Grant lock:
  - If sb_arvalid_s0 = 1 and sb_arready_s0 = 0 at a clock edge, register the grant index and lock it.
  - The locked grant is held until the handshake completes, even if a higher-priority master raises valid.
  - Masters must hold valid and payload stable until ready. Dropping valid while locked releases the lock on the next edge.
- Request forwarding:
  - can_push = !full | (full & response pop this cycle).
  - sb_arvalid_s0 = can_push & |(sb_arvalid_m & gnt).
  - sb_araddr_s0 = payload of the granted master.
  - sb_arready_m = gnt & {NM{can_push & sb_arready_s0}}.
- Accept (sb_arvalid_s0 & sb_arready_s0):
  - Push the granted index into the ID FIFO.
  - Mode 0: RR pointer ← granted index + 1, modulo NM.
- Response routing:
  - head = FIFO head index.
  - sb_rvalid_m[head] = sb_rvalid_s0 & !empty; all other bits 0.
  - sb_rready_s0 = sb_rready_m[head] & !empty.
  - Pop on sb_rvalid_s0 & sb_rready_s0.
- Boundary conditions:
  - FIFO empty: sb_rready_s0 = 0 and all sb_rvalid_m = 0 (stray slave response is blocked, not dropped).
  - FIFO full with no pop: sb_arvalid_s0 = 0 and all sb_arready_m = 0.
  - FIFO full with push and pop in the same cycle: both occur and the count is unchanged.
  - Count uses a $clog2(OSTD)+1 bit counter, with read/write pointers wrapping at OSTD.
- Responses return strictly in request order; the slave must not reorder.
- Reset asserted mid-transaction clears all state immediately. In-flight responses are lost, so the system resets slave and masters together.

Decomposition:
- Package sb_pkg holds:
  - ARB_RR / ARB_FIXED mode constants.
  - Default AW/DW.
  - Function clog2_safe (returns ≥1).
- One natural sub-module, sb_arb_idq: arbiter + grant lock + RR pointer + ID FIFO, parametrised by NM/OSTD/ARB_MODE. It is instantiated twice, once for the read path and once for the write path; payload muxing stays in the top.

Test Plan:
1. NM=2, OSTD=2, mode 0; m0 and m1 both assert arvalid continuously, slave always ready, rvalid one cycle later → grants alternate m0,m1,m0,…; each rdata returns only on the issuing master's rvalid.
2. OSTD=2, slave rvalid withheld → third request sees sb_arvalid_s0=0 and sb_arready_m=0; FIFO count=2; raising rvalid with pop accepts the stalled request in the same cycle.
3. Mode 1, NM=4; m0 is stalled (arready_s0=0 for 3 cycles), then m3 raises valid → m0 stays granted until its handshake, then m3 is granted next.
4. FIFO empty, slave drives rvalid_s0=1 → sb_rready_s0=0 and all sb_rvalid_m=0.
5. Writes from m1 to 0x1000 with wstrb=0x3 and from m0 to 0x2000 with wstrb=0xF interleaved with reads → slave sees correct addr/data/strb per write; bvalid is routed m1 then m0; the read path is unaffected.
6. Assert rst with 2 outstanding reads → all valid/ready outputs 0 asynchronously; after release, count=0 and a new m1 request is granted first (mode 0 pointer=0, no m0 request).
